// File: rtl/swervolf_mem_arb.sv
// Two-master to one-slave AXI4 arbiter for the DDR port.
// Read and write paths have independent round-robin FSMs, with one burst in flight per path.
module swervolf_mem_arb #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_init_done,
    // master 0
    input  logic [ID_WIDTH-1:0]     i_m0_awid,
    input  logic [ADDR_WIDTH-1:0]   i_m0_awaddr,
    input  logic [7:0]              i_m0_awlen,
    input  logic [2:0]              i_m0_awsize,
    input  logic [1:0]              i_m0_awburst,
    input  logic                    i_m0_awvalid,
    output logic                    o_m0_awready,
    input  logic [DATA_WIDTH-1:0]   i_m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_m0_wstrb,
    input  logic                    i_m0_wlast,
    input  logic                    i_m0_wvalid,
    output logic                    o_m0_wready,
    output logic [ID_WIDTH-1:0]     o_m0_bid,
    output logic [1:0]              o_m0_bresp,
    output logic                    o_m0_bvalid,
    input  logic                    i_m0_bready,
    input  logic [ID_WIDTH-1:0]     i_m0_arid,
    input  logic [ADDR_WIDTH-1:0]   i_m0_araddr,
    input  logic [7:0]              i_m0_arlen,
    input  logic [2:0]              i_m0_arsize,
    input  logic [1:0]              i_m0_arburst,
    input  logic                    i_m0_arvalid,
    output logic                    o_m0_arready,
    output logic [ID_WIDTH-1:0]     o_m0_rid,
    output logic [DATA_WIDTH-1:0]   o_m0_rdata,
    output logic [1:0]              o_m0_rresp,
    output logic                    o_m0_rlast,
    output logic                    o_m0_rvalid,
    input  logic                    i_m0_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]     i_m1_awid,
    input  logic [ADDR_WIDTH-1:0]   i_m1_awaddr,
    input  logic [7:0]              i_m1_awlen,
    input  logic [2:0]              i_m1_awsize,
    input  logic [1:0]              i_m1_awburst,
    input  logic                    i_m1_awvalid,
    output logic                    o_m1_awready,
    input  logic [DATA_WIDTH-1:0]   i_m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_m1_wstrb,
    input  logic                    i_m1_wlast,
    input  logic                    i_m1_wvalid,
    output logic                    o_m1_wready,
    output logic [ID_WIDTH-1:0]     o_m1_bid,
    output logic [1:0]              o_m1_bresp,
    output logic                    o_m1_bvalid,
    input  logic                    i_m1_bready,
    input  logic [ID_WIDTH-1:0]     i_m1_arid,
    input  logic [ADDR_WIDTH-1:0]   i_m1_araddr,
    input  logic [7:0]              i_m1_arlen,
    input  logic [2:0]              i_m1_arsize,
    input  logic [1:0]              i_m1_arburst,
    input  logic                    i_m1_arvalid,
    output logic                    o_m1_arready,
    output logic [ID_WIDTH-1:0]     o_m1_rid,
    output logic [DATA_WIDTH-1:0]   o_m1_rdata,
    output logic [1:0]              o_m1_rresp,
    output logic                    o_m1_rlast,
    output logic                    o_m1_rvalid,
    input  logic                    i_m1_rready,
    // slave
    output logic [ID_WIDTH-1:0]     o_awid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic [ID_WIDTH-1:0]     i_bid,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    output logic [ID_WIDTH-1:0]     o_arid,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]              o_arlen,
    output logic [2:0]              o_arsize,
    output logic [1:0]              o_arburst,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    input  logic [ID_WIDTH-1:0]     i_rid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    output logic [1:0]              o_rgnt,
    output logic [1:0]              o_wgnt
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    rstate_t r_rstate, w_rstate_nxt;
    wstate_t r_wstate, w_wstate_nxt;
    logic    r_rsel, w_rsel_nxt, r_rptr, w_rptr_nxt;
    logic    r_wsel, w_wsel_nxt, r_wptr, w_wptr_nxt;

    logic w_arv_sel, w_rready_sel, w_awv_sel, w_wv_sel, w_wlast_sel, w_bready_sel;
    logic w_r_addr, w_r_data, w_w_addr, w_w_data, w_w_resp;
    logic w_rmux, w_wmux;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rsel   <= 1'b0;
            r_rptr   <= 1'b1;
            r_wstate <= W_IDLE;
            r_wsel   <= 1'b0;
            r_wptr   <= 1'b1;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_rsel   <= w_rsel_nxt;
            r_rptr   <= w_rptr_nxt;
            r_wstate <= w_wstate_nxt;
            r_wsel   <= w_wsel_nxt;
            r_wptr   <= w_wptr_nxt;
        end
    end

    assign w_arv_sel    = r_rsel ? i_m1_arvalid : i_m0_arvalid;
    assign w_rready_sel = r_rsel ? i_m1_rready  : i_m0_rready;
    assign w_awv_sel    = r_wsel ? i_m1_awvalid : i_m0_awvalid;
    assign w_wv_sel     = r_wsel ? i_m1_wvalid  : i_m0_wvalid;
    assign w_wlast_sel  = r_wsel ? i_m1_wlast   : i_m0_wlast;
    assign w_bready_sel = r_wsel ? i_m1_bready  : i_m0_bready;

    // Tie goes to the master that was not granted last; a lone requester always wins.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rsel_nxt   = r_rsel;
        w_rptr_nxt   = r_rptr;
        case (r_rstate)
            R_IDLE: if (i_init_done && (i_m0_arvalid || i_m1_arvalid)) begin
                w_rstate_nxt = R_ADDR;
                w_rsel_nxt   = (i_m0_arvalid && i_m1_arvalid) ? ~r_rptr : i_m1_arvalid;
            end
            R_ADDR: if (w_arv_sel && i_arready) w_rstate_nxt = R_DATA;
            R_DATA: if (i_rvalid && w_rready_sel && i_rlast) begin
                w_rstate_nxt = R_IDLE;
                w_rptr_nxt   = r_rsel;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wsel_nxt   = r_wsel;
        w_wptr_nxt   = r_wptr;
        case (r_wstate)
            W_IDLE: if (i_init_done && (i_m0_awvalid || i_m1_awvalid)) begin
                w_wstate_nxt = W_ADDR;
                w_wsel_nxt   = (i_m0_awvalid && i_m1_awvalid) ? ~r_wptr : i_m1_awvalid;
            end
            W_ADDR: if (w_awv_sel && i_awready) w_wstate_nxt = W_DATA;
            W_DATA: if (w_wv_sel && i_wready && w_wlast_sel) w_wstate_nxt = W_RESP;
            W_RESP: if (i_bvalid && w_bready_sel) begin
                w_wstate_nxt = W_IDLE;
                w_wptr_nxt   = r_wsel;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    assign w_r_addr = (r_rstate == R_ADDR);
    assign w_r_data = (r_rstate == R_DATA);
    assign w_w_addr = (r_wstate == W_ADDR);
    assign w_w_data = (r_wstate == W_DATA);
    assign w_w_resp = (r_wstate == W_RESP);

    assign o_rgnt = (r_rstate == R_IDLE) ? 2'b00 : (r_rsel ? 2'b10 : 2'b01);
    assign o_wgnt = (r_wstate == W_IDLE) ? 2'b00 : (r_wsel ? 2'b10 : 2'b01);

    // Payload muxes fall back to master 0 whenever master 1 does not hold the grant.
    assign w_rmux = o_rgnt[1];
    assign w_wmux = o_wgnt[1];

    assign o_arid    = w_rmux ? i_m1_arid    : i_m0_arid;
    assign o_araddr  = w_rmux ? i_m1_araddr  : i_m0_araddr;
    assign o_arlen   = w_rmux ? i_m1_arlen   : i_m0_arlen;
    assign o_arsize  = w_rmux ? i_m1_arsize  : i_m0_arsize;
    assign o_arburst = w_rmux ? i_m1_arburst : i_m0_arburst;
    assign o_arvalid = w_r_addr & w_arv_sel;
    assign o_m0_arready = w_r_addr & ~r_rsel & i_arready;
    assign o_m1_arready = w_r_addr &  r_rsel & i_arready;

    assign o_rready    = w_r_data & w_rready_sel;
    assign o_m0_rvalid = w_r_data & ~r_rsel & i_rvalid;
    assign o_m1_rvalid = w_r_data &  r_rsel & i_rvalid;
    assign o_m0_rid    = i_rid;
    assign o_m1_rid    = i_rid;
    assign o_m0_rdata  = i_rdata;
    assign o_m1_rdata  = i_rdata;
    assign o_m0_rresp  = i_rresp;
    assign o_m1_rresp  = i_rresp;
    assign o_m0_rlast  = i_rlast;
    assign o_m1_rlast  = i_rlast;

    assign o_awid    = w_wmux ? i_m1_awid    : i_m0_awid;
    assign o_awaddr  = w_wmux ? i_m1_awaddr  : i_m0_awaddr;
    assign o_awlen   = w_wmux ? i_m1_awlen   : i_m0_awlen;
    assign o_awsize  = w_wmux ? i_m1_awsize  : i_m0_awsize;
    assign o_awburst = w_wmux ? i_m1_awburst : i_m0_awburst;
    assign o_awvalid = w_w_addr & w_awv_sel;
    assign o_m0_awready = w_w_addr & ~r_wsel & i_awready;
    assign o_m1_awready = w_w_addr &  r_wsel & i_awready;

    assign o_wdata  = w_wmux ? i_m1_wdata : i_m0_wdata;
    assign o_wstrb  = w_wmux ? i_m1_wstrb : i_m0_wstrb;
    assign o_wlast  = w_wmux ? i_m1_wlast : i_m0_wlast;
    assign o_wvalid = w_w_data & w_wv_sel;
    assign o_m0_wready = w_w_data & ~r_wsel & i_wready;
    assign o_m1_wready = w_w_data &  r_wsel & i_wready;

    assign o_bready    = w_w_resp & w_bready_sel;
    assign o_m0_bvalid = w_w_resp & ~r_wsel & i_bvalid;
    assign o_m1_bvalid = w_w_resp &  r_wsel & i_bvalid;
    assign o_m0_bid    = i_bid;
    assign o_m1_bid    = i_bid;
    assign o_m0_bresp  = i_bresp;
    assign o_m1_bresp  = i_bresp;

endmodule

// File: tb/tb_swervolf_mem_arb.sv
// Self-checking bench for swervolf_mem_arb: read-path vector table, directed corner
// sequences, and randomized traffic checked against a transaction-level arbitration model.
module tb_swervolf_mem_arb;
    localparam int IW = 6, AW = 32, DW = 64, SW = DW / 8;

    logic clk = 1'b0;
    logic rst, i_init_done;
    logic [IW-1:0] i_m0_awid, i_m1_awid, i_m0_arid, i_m1_arid, i_bid, i_rid;
    logic [AW-1:0] i_m0_awaddr, i_m1_awaddr, i_m0_araddr, i_m1_araddr;
    logic [7:0]    i_m0_awlen, i_m1_awlen, i_m0_arlen, i_m1_arlen;
    logic [2:0]    i_m0_awsize, i_m1_awsize, i_m0_arsize, i_m1_arsize;
    logic [1:0]    i_m0_awburst, i_m1_awburst, i_m0_arburst, i_m1_arburst, i_bresp, i_rresp;
    logic          i_m0_awvalid, i_m1_awvalid, i_m0_arvalid, i_m1_arvalid;
    logic [DW-1:0] i_m0_wdata, i_m1_wdata, i_rdata;
    logic [SW-1:0] i_m0_wstrb, i_m1_wstrb;
    logic          i_m0_wlast, i_m1_wlast, i_m0_wvalid, i_m1_wvalid;
    logic          i_m0_bready, i_m1_bready, i_m0_rready, i_m1_rready;
    logic          i_awready, i_wready, i_bvalid, i_arready, i_rlast, i_rvalid;

    logic          o_m0_awready, o_m1_awready, o_m0_wready, o_m1_wready, o_m0_arready, o_m1_arready;
    logic [IW-1:0] o_m0_bid, o_m1_bid, o_m0_rid, o_m1_rid, o_awid, o_arid;
    logic [1:0]    o_m0_bresp, o_m1_bresp, o_m0_rresp, o_m1_rresp;
    logic          o_m0_bvalid, o_m1_bvalid, o_m0_rvalid, o_m1_rvalid, o_m0_rlast, o_m1_rlast;
    logic [DW-1:0] o_m0_rdata, o_m1_rdata, o_wdata;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [7:0]    o_awlen, o_arlen;
    logic [2:0]    o_awsize, o_arsize;
    logic [1:0]    o_awburst, o_arburst, o_rgnt, o_wgnt;
    logic          o_awvalid, o_wlast, o_wvalid, o_bready, o_arvalid, o_rready;
    logic [SW-1:0] o_wstrb;

    swervolf_mem_arb #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .i_init_done(i_init_done),
        .i_m0_awid(i_m0_awid), .i_m0_awaddr(i_m0_awaddr), .i_m0_awlen(i_m0_awlen),
        .i_m0_awsize(i_m0_awsize), .i_m0_awburst(i_m0_awburst), .i_m0_awvalid(i_m0_awvalid),
        .o_m0_awready(o_m0_awready), .i_m0_wdata(i_m0_wdata), .i_m0_wstrb(i_m0_wstrb),
        .i_m0_wlast(i_m0_wlast), .i_m0_wvalid(i_m0_wvalid), .o_m0_wready(o_m0_wready),
        .o_m0_bid(o_m0_bid), .o_m0_bresp(o_m0_bresp), .o_m0_bvalid(o_m0_bvalid), .i_m0_bready(i_m0_bready),
        .i_m0_arid(i_m0_arid), .i_m0_araddr(i_m0_araddr), .i_m0_arlen(i_m0_arlen),
        .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst), .i_m0_arvalid(i_m0_arvalid),
        .o_m0_arready(o_m0_arready), .o_m0_rid(o_m0_rid), .o_m0_rdata(o_m0_rdata),
        .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast), .o_m0_rvalid(o_m0_rvalid), .i_m0_rready(i_m0_rready),
        .i_m1_awid(i_m1_awid), .i_m1_awaddr(i_m1_awaddr), .i_m1_awlen(i_m1_awlen),
        .i_m1_awsize(i_m1_awsize), .i_m1_awburst(i_m1_awburst), .i_m1_awvalid(i_m1_awvalid),
        .o_m1_awready(o_m1_awready), .i_m1_wdata(i_m1_wdata), .i_m1_wstrb(i_m1_wstrb),
        .i_m1_wlast(i_m1_wlast), .i_m1_wvalid(i_m1_wvalid), .o_m1_wready(o_m1_wready),
        .o_m1_bid(o_m1_bid), .o_m1_bresp(o_m1_bresp), .o_m1_bvalid(o_m1_bvalid), .i_m1_bready(i_m1_bready),
        .i_m1_arid(i_m1_arid), .i_m1_araddr(i_m1_araddr), .i_m1_arlen(i_m1_arlen),
        .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst), .i_m1_arvalid(i_m1_arvalid),
        .o_m1_arready(o_m1_arready), .o_m1_rid(o_m1_rid), .o_m1_rdata(o_m1_rdata),
        .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast), .o_m1_rvalid(o_m1_rvalid), .i_m1_rready(i_m1_rready),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready), .o_rgnt(o_rgnt), .o_wgnt(o_wgnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        {i_m0_awid, i_m1_awid, i_m0_arid, i_m1_arid, i_bid, i_rid} = '0;
        {i_m0_awaddr, i_m1_awaddr, i_m0_araddr, i_m1_araddr} = '0;
        {i_m0_awlen, i_m1_awlen, i_m0_arlen, i_m1_arlen} = '0;
        {i_m0_awsize, i_m1_awsize, i_m0_arsize, i_m1_arsize} = '0;
        {i_m0_awburst, i_m1_awburst, i_m0_arburst, i_m1_arburst, i_bresp, i_rresp} = '0;
        {i_m0_awvalid, i_m1_awvalid, i_m0_arvalid, i_m1_arvalid} = '0;
        {i_m0_wdata, i_m1_wdata, i_rdata, i_m0_wstrb, i_m1_wstrb} = '0;
        {i_m0_wlast, i_m1_wlast, i_m0_wvalid, i_m1_wvalid} = '0;
        {i_m0_bready, i_m1_bready, i_m0_rready, i_m1_rready} = '0;
        {i_awready, i_wready, i_bvalid, i_arready, i_rlast, i_rvalid} = '0;
        i_init_done = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One row: read-path inputs for a cycle and the outputs expected during it.
    typedef struct {
        bit       init, v0, v1, arrdy, rv, rl, rr0, rr1;
        bit [1:0] gnt;
        bit       arv, ar0, ar1, rv0, rv1, rrdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad, beat, fwd;
        logic [1:0] prev;
        logic [1:0] order[$];
        logic [1:0] exp_order[3];
        logic [7:0] strb_exp;

        rst = 1'b1;
        clear_inputs();

        // ---------------- read-path vector table ----------------
        tbl[0] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[3] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b01, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[4] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b01, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[5] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 2'b01, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};
        tbl[6] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[7] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b10, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 2'b10, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
        tbl[9] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

        do_reset();
        #1;
        chk("reset_outputs", {o_rgnt, o_wgnt, o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}, '0);
        for (int i = 0; i < 10; i++) begin
            i_init_done  = tbl[i].init;
            i_m0_arvalid = tbl[i].v0;
            i_m1_arvalid = tbl[i].v1;
            i_arready    = tbl[i].arrdy;
            i_rvalid     = tbl[i].rv;
            i_rlast      = tbl[i].rl;
            i_m0_rready  = tbl[i].rr0;
            i_m1_rready  = tbl[i].rr1;
            #1;
            chk($sformatf("rtbl%0d", i),
                {o_rgnt, o_arvalid, o_m0_arready, o_m1_arready, o_m0_rvalid, o_m1_rvalid, o_rready},
                {tbl[i].gnt, tbl[i].arv, tbl[i].ar0, tbl[i].ar1, tbl[i].rv0, tbl[i].rv1, tbl[i].rrdy});
            tick();
        end

        // ---------------- init_done gating ----------------
        do_reset();
        i_m0_arvalid = 1'b1;
        i_m0_araddr  = 32'h8000_1000;
        bad = 0;
        repeat (100) begin
            #1;
            if (o_arvalid || o_rgnt != 2'b00) bad++;
            tick();
        end
        chk("init_hold", bad, 0);
        i_init_done = 1'b1;
        #1;
        chk("init_T_arvalid", o_arvalid, 0);
        tick();
        chk("init_T1_arvalid", o_arvalid, 1);
        chk("init_T1_araddr", o_araddr, 32'h8000_1000);
        chk("init_T1_rgnt", o_rgnt, 2'b01);

        // ---------------- tie: m0 first, 4 beats, then m1 ----------------
        do_reset();
        i_init_done = 1'b1;
        i_m0_arvalid = 1'b1; i_m0_arid = 6'd5; i_m0_arlen = 8'd3;
        i_m1_arvalid = 1'b1; i_m1_arid = 6'd9; i_m1_arlen = 8'd3;
        tick();
        chk("tie_arid_m0", o_arid, 6'd5);
        chk("tie_rgnt_m0", o_rgnt, 2'b01);
        i_arready = 1'b1;
        #1;
        chk("tie_arready", {o_m1_arready, o_m0_arready}, 2'b01);
        tick();
        i_m0_arvalid = 1'b0; i_arready = 1'b0;
        i_rvalid = 1'b1; i_rid = 6'd5; i_m0_rready = 1'b1; i_m1_rready = 1'b1;
        bad = 0;
        for (int b = 0; b < 4; b++) begin
            i_rlast = (b == 3);
            #1;
            if (!o_m0_rvalid || o_m0_rid != 6'd5 || o_m1_rvalid || o_arvalid) bad++;
            tick();
        end
        chk("tie_m0_burst", bad, 0);
        i_rvalid = 1'b0; i_rlast = 1'b0;
        #1;
        chk("tie_idle_gap", o_arvalid, 0);
        tick();
        chk("tie_arid_m1", {o_rgnt, o_arvalid, 2'b00, o_arid}, {2'b10, 1'b1, 2'b00, 6'd9});
        i_arready = 1'b1;
        tick();
        i_m1_arvalid = 1'b0; i_arready = 1'b0;
        i_rvalid = 1'b1; i_rlast = 1'b1; i_rid = 6'd9;
        #1;
        chk("tie_m1_beat", {o_m1_rvalid, o_m0_rvalid, 2'b00, o_m1_rid}, {1'b1, 1'b0, 2'b00, 6'd9});
        tick();

        // ---------------- back-to-back m0 vs pending m1 ----------------
        do_reset();
        i_init_done = 1'b1;
        i_m0_arvalid = 1'b1; i_m1_arvalid = 1'b1;
        i_arready = 1'b1; i_rvalid = 1'b1; i_rlast = 1'b1;
        i_m0_rready = 1'b1; i_m1_rready = 1'b1;
        prev = 2'b00; bad = 0;
        order.delete();
        for (int c = 0; c < 12; c++) begin
            logic drop;
            #1;
            if (o_rgnt == 2'b11) bad++;
            if (o_rgnt != 2'b00 && prev == 2'b00) order.push_back(o_rgnt);
            prev = o_rgnt;
            drop = o_m1_arready;
            tick();
            if (drop) i_m1_arvalid = 1'b0;
        end
        chk("rr_onehot", bad, 0);
        exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01;
        for (int k = 0; k < 3; k++)
            chk($sformatf("rr_order%0d", k), (k < order.size()) ? order[k] : 2'b00, exp_order[k]);

        // ---------------- m1 write, wready toggling, m0 AW waits ----------------
        do_reset();
        i_init_done = 1'b1;
        i_m1_awvalid = 1'b1; i_m1_awid = 6'h2A; i_m1_awlen = 8'd1;
        tick();
        i_m0_awvalid = 1'b1; i_awready = 1'b1;
        #1;
        chk("w_aw_m1", {o_wgnt, o_m1_awready, o_m0_awready}, {2'b10, 1'b1, 1'b0});
        tick();
        i_m1_awvalid = 1'b0;
        beat = 0; fwd = 0; bad = 0;
        for (int c = 0; c < 10 && beat < 2; c++) begin
            i_wready    = (c % 2 == 1);
            i_m1_wvalid = 1'b1;
            i_m1_wstrb  = (beat == 0) ? 8'h0F : 8'hF0;
            i_m1_wdata  = 64'h1111_0000_0000_0000 + 64'(beat);
            i_m1_wlast  = (beat == 1);
            #1;
            if (o_m0_awready) bad++;
            if (o_wvalid && i_wready) begin
                strb_exp = (fwd == 0) ? 8'h0F : 8'hF0;
                chk($sformatf("w_strb%0d", fwd), o_wstrb, strb_exp);
                fwd++;
                beat++;
            end
            tick();
        end
        chk("w_beats", fwd, 2);
        i_m1_wvalid = 1'b1; i_wready = 1'b1;
        i_bvalid = 1'b1; i_bid = 6'h2A; i_m1_bready = 1'b1;
        #1;
        chk("w_resp_route", {o_m1_bvalid, o_m0_bvalid, o_wvalid, o_m1_wready, o_bready, o_m1_bid},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h2A});
        chk("w_m0_aw_wait", bad + int'(o_m0_awready), 0);
        tick();
        i_bvalid = 1'b0; i_m1_wvalid = 1'b0; i_wready = 1'b0;
        #1;
        chk("w_idle_m0_aw", o_m0_awready, 0);
        tick();
        chk("w_m0_aw_granted", {o_wgnt, o_m0_awready}, {2'b01, 1'b1});

        // ---------------- concurrent read m0 / write m1 ----------------
        do_reset();
        i_init_done = 1'b1;
        i_m0_arvalid = 1'b1; i_m1_awvalid = 1'b1;
        tick();
        chk("cc_grants", {o_rgnt, o_wgnt}, 4'b0110);
        i_arready = 1'b1; i_awready = 1'b1;
        #1;
        chk("cc_addr_hs", {o_m0_arready, o_m1_awready}, 2'b11);
        tick();
        i_m0_arvalid = 1'b0; i_m1_awvalid = 1'b0;
        i_rvalid = 1'b1; i_rlast = 1'b1; i_m0_rready = 1'b1;
        i_m1_wvalid = 1'b1; i_m1_wlast = 1'b1; i_wready = 1'b1;
        #1;
        chk("cc_data", {o_m0_rvalid, o_rready, o_m1_wready, o_wvalid}, 4'b1111);
        tick();
        i_rvalid = 1'b0; i_m1_wvalid = 1'b0;
        i_bvalid = 1'b1; i_m1_bready = 1'b1;
        #1;
        chk("cc_resp", {o_rgnt, o_wgnt, o_m1_bvalid, o_bready}, {2'b00, 2'b10, 1'b1, 1'b1});
        tick();

        // ---------------- reset mid-burst ----------------
        do_reset();
        i_init_done = 1'b1;
        i_m0_arvalid = 1'b1; i_m0_arlen = 8'd3;
        tick();
        i_arready = 1'b1;
        tick();
        i_m0_arvalid = 1'b0; i_arready = 1'b0;
        i_rvalid = 1'b1; i_rlast = 1'b0; i_m0_rready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_m1_arvalid = 1'b1;
        #1;
        chk("rst_mid_outputs", {o_rgnt, o_wgnt, o_arvalid, o_rready, o_m0_rvalid, o_m1_rvalid,
            o_m0_arready, o_m1_arready, o_awvalid, o_wvalid, o_bready}, '0);
        tick();
        i_arready = 1'b1;
        #1;
        chk("rst_then_m1", {o_rgnt, o_arvalid, o_m1_arready}, {2'b10, 1'b1, 1'b1});

        // ---------------- randomized traffic vs reference model ----------------
        begin
            bit rb, rown, rad, rlst, wb, wown, wlst;
            int wph;
            logic [1:0] arv, rrm, awv, wvm, wlm, brm, e_rg, e_wg, e_arr, e_rv, e_awr, e_wr, e_bv;
            logic e_arv, e_rrdy, e_awv, e_wv, e_brdy;

            do_reset();
            rb = 0; rad = 0; rown = 0; rlst = 1;
            wb = 0; wph = 0; wown = 0; wlst = 1;
            for (int c = 0; c < 3000; c++) begin
                i_init_done  = ($urandom_range(0, 15) != 0);
                i_m0_arvalid = 1'($urandom); i_m1_arvalid = 1'($urandom);
                i_m0_awvalid = 1'($urandom); i_m1_awvalid = 1'($urandom);
                i_m0_wvalid  = 1'($urandom); i_m1_wvalid  = 1'($urandom);
                i_m0_wlast   = 1'($urandom); i_m1_wlast   = 1'($urandom);
                i_m0_rready  = 1'($urandom); i_m1_rready  = 1'($urandom);
                i_m0_bready  = 1'($urandom); i_m1_bready  = 1'($urandom);
                i_arready = 1'($urandom); i_awready = 1'($urandom); i_wready = 1'($urandom);
                i_rvalid  = 1'($urandom); i_rlast   = ($urandom_range(0, 3) == 0);
                i_bvalid  = 1'($urandom);
                i_m0_araddr = $urandom; i_m1_araddr = $urandom;
                i_m0_awaddr = $urandom; i_m1_awaddr = $urandom;
                i_m0_wstrb  = 8'($urandom); i_m1_wstrb = 8'($urandom);
                i_rid = 6'($urandom); i_bid = 6'($urandom);
                #1;
                arv = {i_m1_arvalid, i_m0_arvalid}; rrm = {i_m1_rready, i_m0_rready};
                awv = {i_m1_awvalid, i_m0_awvalid}; wvm = {i_m1_wvalid, i_m0_wvalid};
                wlm = {i_m1_wlast, i_m0_wlast};     brm = {i_m1_bready, i_m0_bready};

                e_rg   = rb ? (rown ? 2'b10 : 2'b01) : 2'b00;
                e_arv  = rb && !rad && arv[rown];
                e_arr  = (rb && !rad && i_arready) ? e_rg : 2'b00;
                e_rv   = (rb && rad && i_rvalid) ? e_rg : 2'b00;
                e_rrdy = rb && rad && rrm[rown];
                chk("rnd_read", {o_rgnt, o_arvalid, o_m1_arready, o_m0_arready, o_m1_rvalid, o_m0_rvalid, o_rready},
                    {e_rg, e_arv, e_arr, e_rv, e_rrdy});
                if (e_arv) chk("rnd_araddr", o_araddr, rown ? i_m1_araddr : i_m0_araddr);

                e_wg   = wb ? (wown ? 2'b10 : 2'b01) : 2'b00;
                e_awv  = wb && wph == 0 && awv[wown];
                e_awr  = (wb && wph == 0 && i_awready) ? e_wg : 2'b00;
                e_wv   = wb && wph == 1 && wvm[wown];
                e_wr   = (wb && wph == 1 && i_wready) ? e_wg : 2'b00;
                e_bv   = (wb && wph == 2 && i_bvalid) ? e_wg : 2'b00;
                e_brdy = wb && wph == 2 && brm[wown];
                chk("rnd_write", {o_wgnt, o_awvalid, o_m1_awready, o_m0_awready, o_wvalid,
                    o_m1_wready, o_m0_wready, o_m1_bvalid, o_m0_bvalid, o_bready},
                    {e_wg, e_awv, e_awr, e_wv, e_wr, e_bv, e_brdy});
                if (e_awv) chk("rnd_awaddr", o_awaddr, wown ? i_m1_awaddr : i_m0_awaddr);
                if (e_wv)  chk("rnd_wstrb", o_wstrb, wown ? i_m1_wstrb : i_m0_wstrb);
                if (e_rv != 2'b00) chk("rnd_rid", e_rv[1] ? o_m1_rid : o_m0_rid, i_rid);

                if (!rb) begin
                    if (i_init_done && arv != 2'b00) begin
                        rb = 1; rad = 0;
                        rown = (arv == 2'b11) ? !rlst : arv[1];
                    end
                end else if (!rad) begin
                    if (arv[rown] && i_arready) rad = 1;
                end else if (i_rvalid && rrm[rown] && i_rlast) begin
                    rb = 0; rlst = rown;
                end

                if (!wb) begin
                    if (i_init_done && awv != 2'b00) begin
                        wb = 1; wph = 0;
                        wown = (awv == 2'b11) ? !wlst : awv[1];
                    end
                end else if (wph == 0) begin
                    if (awv[wown] && i_awready) wph = 1;
                end else if (wph == 1) begin
                    if (wvm[wown] && i_wready && wlm[wown]) wph = 2;
                end else if (i_bvalid && brm[wown]) begin
                    wb = 0; wlst = wown;
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/swervolf_mem_arb.md
Name: swervolf_mem_arb

Overview:
- Two-master to one-slave AXI4 arbiter placed in front of the DDR memory port. It sits between the CPU AXI master plus a second master (DMA or debug loader) and the clock-domain-crossing stage that feeds the DDR controller.
- The read path and the write path are arbitrated independently, with round-robin priority.
- Each path carries one burst in flight at a time.
- No grant is issued until the DDR controller reports init done.

Parameters:
- ID_WIDTH, 6, AXI ID width. IDs pass through unmodified.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width. Strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- i_init_done  in  1  DDR controller init done. Arbitration is enabled only while this is 1.
- i_mN_aw{id,addr,len,size,burst,valid} / o_mN_awready  in/out  ID/ADDR/8/3/2/1 / 1  master N write address channel, N=0,1.
- i_mN_w{data,strb,last,valid} / o_mN_wready  in/out  DATA/DATA/8/1/1 / 1  master N write data channel.
- o_mN_b{id,resp,valid} / i_mN_bready  out/in  ID/2/1 / 1  master N write response channel.
- i_mN_ar{id,addr,len,size,burst,valid} / o_mN_arready  in/out  as AW  master N read address channel.
- o_mN_r{id,data,resp,last,valid} / i_mN_rready  out/in  ID/DATA/2/1/1 / 1  master N read data channel.
- o_aw*, i_awready, o_w*, i_wready, i_b*, o_bready, o_ar*, i_arready, i_r*, o_rready  slave side, same fields and widths as the master side.
- o_rgnt  out  2  one-hot read grant, bit N = master N. 0 when idle.
- o_wgnt  out  2  one-hot write grant, same encoding.

Behaviour:
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE -> R_ADDR when i_init_done=1 and any i_mN_arvalid=1. The grant is registered, so o_arvalid rises the cycle after the request is first seen.
  - R_ADDR: o_ar* = granted master's ar*. o_mN_arready = i_arready for the granted master only. On AR handshake -> R_DATA.
  - R_DATA: R channel routed to the granted master. o_rready = i_mN_rready of the granted master. On R handshake with i_rlast=1 -> R_IDLE, and the read pointer is updated.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE -> W_ADDR: same entry rule as the read FSM, using awvalid.
  - W_ADDR: AW forwarded from the granted master.
  - W_DATA: W forwarded from the granted master. On W handshake with wlast=1 -> W_RESP.
  - W_RESP: B routed to the granted master. On B handshake -> W_IDLE, and the write pointer is updated.
- W beats and ordering:
  - W beats from a master are not accepted before that master's AW is granted; its wready stays 0. This is AXI-legal because a master must not wait for wready before asserting awvalid.
  - The slave must accept AW before W.
- Round-robin:
  - Each path keeps a last-granted pointer, reset to master 1, so master 0 wins the first tie.
  - With both requesting in IDLE, the master that is not the last-granted one wins.
  - A lone requester is always granted.
  - The pointer updates only on completion.
- Non-granted masters and IDLE states:
  - Non-granted masters see all ready/valid outputs at 0.
  - In IDLE states, o_arvalid, o_awvalid, o_wvalid, o_rready and o_bready are 0, and so are all master-side ready/valid outputs.
  - Payload outputs are don't-care while their valid is low. They are implemented as a mux selected by grant, with master 0 as the default.
- i_init_done behaviour:
  - i_init_done=0 holds both FSMs in IDLE.
  - If i_init_done drops mid-transaction, the transaction completes and no new grant is issued.
- Read and write paths never interact. Concurrent grants to different masters, or to the same master, are allowed.
- Beyond the registered grant, all handshakes are combinational pass-throughs: zero added latency per beat, full throughput within a burst.
- Reset:
  - Synchronous rst forces both FSMs to IDLE, both grants to 0, and both pointers to master 1.
  - All valid/ready outputs are 0 in the cycle after rst is sampled high.
  - An in-flight burst is abandoned. The slave is reset in the same domain.
- Burst length: any AXI len 0..255 is supported; completion is detected by last, not by counting beats.

Test Plan:
- i_init_done=0, m0 arvalid held high for 100 cycles -> o_arvalid=0 and o_rgnt=0 throughout. Raise i_init_done at cycle T -> o_arvalid=1 at T+1 with m0's araddr.
- After reset, m0 and m1 both assert arvalid (len=3, ids 5 and 9) -> m0 is granted first and receives 4 beats with rid=5. m1's AR is issued only after m0's rlast handshake, and m1 receives rid=9. m1 never sees rvalid during m0's burst.
- m0 issues continuous back-to-back reads while m1 has one read pending -> grant order is m0, m1, m0. o_rgnt never has 2 bits set.
- m1 write with len=1, i_wready toggling 0/1 every cycle -> exactly 2 beats are forwarded with correct strb. bid is routed to m1. A pending m0 AW is accepted only after m1's B handshake.
- m0 read and m1 write issued in the same cycle -> o_rgnt=01 and o_wgnt=10 in the same cycle, and both complete without stalling each other.
- rst asserted in R_DATA at beat 2 of 4 -> all valid/ready outputs and o_rgnt are 0 in the next cycle. After release, an m1-only request is granted normally.
